// File: rtl/ysyx_23060236_pkg.sv
// Shared definitions for the ysyx_23060236 load/store unit: funct3 size codes,
// FSM state encoding and the access-size decode helper.
package ysyx_23060236_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_e;

  // Unsigned byte/half codes only exist for loads; any unknown code is a word.
  function automatic acc_size_e access_size(input logic [2:0] funct3, input logic is_store);
    acc_size_e size;
    size = SZ_W;
    if (funct3 == F3_B || (!is_store && funct3 == F3_BU)) begin
      size = SZ_B;
    end else if (funct3 == F3_H || (!is_store && funct3 == F3_HU)) begin
      size = SZ_H;
    end
    return size;
  endfunction

endpackage

// File: rtl/ysyx_23060236_lsu_if.sv
// Single-outstanding request/response memory port used by the load/store unit.
interface ysyx_23060236_lsu_if #(
  parameter int ADDR_W = 32
);

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_wen;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_req_wdata;
  logic [3:0]        mem_req_wstrb;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_rdata;
  logic              mem_rsp_err;

  modport master (
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

endinterface

// File: rtl/ysyx_23060236_lsu_align.sv
// Combinational byte-lane logic: store strobes/replication, load extract and
// extension, and the misalignment flag for a given size and address offset.
module ysyx_23060236_lsu_align
  import ysyx_23060236_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  acc_size_e   size;
  logic [15:0] shifted;

  always_comb begin
    size       = access_size(funct3, is_store);
    shifted    = 16'(load_word >> {offset, 3'b000});
    wstrb      = 4'b1111;
    wdata      = store_data;
    load_data  = load_word;
    misaligned = (offset != 2'b00);
    case (size)
      SZ_B: begin
        wstrb      = 4'b0001 << offset;
        wdata      = {4{store_data[7:0]}};
        load_data  = funct3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        misaligned = 1'b0;
      end
      SZ_H: begin
        wstrb      = 4'b0011 << offset;
        wdata      = {2{store_data[15:0]}};
        load_data  = funct3[2] ? {16'b0, shifted} : {{16{shifted[15]}}, shifted};
        misaligned = offset[0];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/ysyx_23060236_lsu.sv
// Load/store stage: accepts one instruction, runs at most one memory access,
// and hands the result to writeback over a valid/ready handshake.
module ysyx_23060236_lsu
  import ysyx_23060236_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [2:0]          in_funct3,
  input  logic                in_ren,
  input  logic                in_wen,
  input  logic [3:0]          in_rd,
  input  logic                in_reg_wen,
  ysyx_23060236_lsu_if.master mem,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_rd,
  output logic                out_reg_wen,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_fault
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_funct3;
  logic              r_store;
  logic              r_load;
  logic              r_reg_wen;

  logic              sel_in;
  logic [2:0]        al_funct3;
  logic              al_store;
  logic [1:0]        al_offset;
  logic [3:0]        al_wstrb;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;
  logic              al_misaligned;

  // In IDLE the aligner judges the incoming instruction; afterwards it formats the latched one.
  assign sel_in    = (state == ST_IDLE);
  assign al_funct3 = sel_in ? in_funct3 : r_funct3;
  assign al_store  = sel_in ? in_wen : r_store;
  assign al_offset = sel_in ? in_addr[1:0] : r_addr[1:0];

  ysyx_23060236_lsu_align u_align (
    .funct3     (al_funct3),
    .is_store   (al_store),
    .offset     (al_offset),
    .store_data (r_wdata),
    .load_word  (mem.mem_rsp_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_rdata),
    .misaligned (al_misaligned)
  );

  assign in_ready          = (state == ST_IDLE);
  assign out_valid         = (state == ST_DONE);
  assign mem.mem_req_valid = (state == ST_REQ);
  assign mem.mem_req_wen   = r_store;
  assign mem.mem_req_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem.mem_req_wdata = al_wdata;
  assign mem.mem_req_wstrb = r_store ? al_wstrb : 4'b0000;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_funct3    <= 3'b000;
      r_store     <= 1'b0;
      r_load      <= 1'b0;
      r_reg_wen   <= 1'b0;
      out_rd      <= 4'd0;
      out_reg_wen <= 1'b0;
      out_data    <= '0;
      out_fault   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            r_addr    <= in_addr;
            r_wdata   <= in_wdata;
            r_funct3  <= in_funct3;
            r_store   <= in_wen;
            r_load    <= in_ren & ~in_wen;
            r_reg_wen <= in_reg_wen;
            out_rd    <= in_rd;
            if (!in_ren && !in_wen) begin
              out_data    <= DATA_W'(in_addr);
              out_reg_wen <= in_reg_wen;
              out_fault   <= 1'b0;
              state       <= ST_DONE;
            end else if (al_misaligned) begin
              out_data    <= DATA_W'(in_addr);
              out_reg_wen <= 1'b0;
              out_fault   <= 1'b1;
              state       <= ST_DONE;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem.mem_req_ready) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem.mem_rsp_valid) begin
            out_fault   <= mem.mem_rsp_err;
            out_reg_wen <= r_load & r_reg_wen & ~mem.mem_rsp_err;
            out_data    <= r_store ? DATA_W'(r_addr) : al_rdata;
            state       <= ST_DONE;
          end
        end
        default: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
